// File: rtl/bram_region_reader_pkg.sv
// rtl/bram_region_reader_pkg.sv - shared types and constants for the BRAM region reader
package bram_region_reader_pkg;

    localparam int LOG2_INTERNAL_SIZE = 12;

    typedef enum logic [1:0] {
        READER_STATE_IDLE,
        READER_STATE_ISSUE,
        READER_STATE_DRAIN,
        READER_STATE_DONE
    } t_readerstate;

    typedef struct packed {
        logic [15:0] offset;
        logic [15:0] length;
    } bram_access_properties;

endpackage

// File: rtl/bram_region_reader_if.sv
// rtl/bram_region_reader_if.sv - control, BRAM read and stream signals of the region reader (BRAM_READER_REPEAT_EN adds repeat_cnt)
interface bram_region_reader_if #(
    parameter int WIDTH      = 512,
    parameter int LOG2_DEPTH = bram_region_reader_pkg::LOG2_INTERNAL_SIZE
);
    import bram_region_reader_pkg::*;

    logic                  start;
    bram_access_properties access;
`ifdef BRAM_READER_REPEAT_EN
    logic [15:0]           repeat_cnt;
`endif
    logic                  busy;
    logic                  done;
    logic                  bram_re;
    logic [LOG2_DEPTH-1:0] bram_raddr;
    logic [WIDTH-1:0]      bram_rdata;
    logic                  bram_rvalid;
    logic                  out_almostfull;
    logic                  out_rvalid;
    logic [WIDTH-1:0]      out_rdata;

    modport master (
        input  start, access, bram_rdata, bram_rvalid, out_almostfull,
`ifdef BRAM_READER_REPEAT_EN
        input  repeat_cnt,
`endif
        output busy, done, bram_re, bram_raddr, out_rvalid, out_rdata
    );

    modport slave (
        output start, access, bram_rdata, bram_rvalid, out_almostfull,
`ifdef BRAM_READER_REPEAT_EN
        output repeat_cnt,
`endif
        input  busy, done, bram_re, bram_raddr, out_rvalid, out_rdata
    );

endinterface

// File: rtl/bram_region_reader.sv
// rtl/bram_region_reader.sv - streams a contiguous BRAM region to a consumer (BRAM_READER_REPEAT_EN enables region replay)
module bram_region_reader
    import bram_region_reader_pkg::*;
#(
    parameter int WIDTH      = 512,
    parameter int LOG2_DEPTH = LOG2_INTERNAL_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bram_region_reader_if.master bus
);

    t_readerstate          r_state;
    logic [15:0]           r_offset;
    logic [15:0]           r_length;
    logic [15:0]           r_issued;
    logic [15:0]           r_received;
    logic [15:0]           r_pass;
    logic [15:0]           r_rx_pass;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_bram_re;
    logic [LOG2_DEPTH-1:0] r_bram_raddr;
    logic                  r_out_rvalid;
    logic [WIDTH-1:0]      r_out_rdata;

    // Index of the final pass; a single pass when replay is not built in.
    logic [15:0]           w_rep_m1;
`ifdef BRAM_READER_REPEAT_EN
    logic [15:0]           r_rep_m1;
    assign w_rep_m1 = r_rep_m1;
`else
    assign w_rep_m1 = 16'd0;
`endif

    logic [15:0] w_addr_sum;
    logic        w_can_issue;
    logic        w_line_end;
    logic        w_last_issue;
    logic        w_issue_wrap;
    logic        w_accept;
    logic        w_rx_wrap;

    // Address arithmetic is 16 bit; the slice below gives the intended wrap modulo the BRAM depth.
    assign w_addr_sum   = r_offset + r_issued;
    assign w_can_issue  = (r_issued != r_length) && !bus.out_almostfull;
    assign w_line_end   = (r_issued == r_length - 16'd1);
    assign w_last_issue = w_line_end && (r_pass == w_rep_m1);
    assign w_issue_wrap = w_line_end && (r_pass != w_rep_m1);
    // Responses are only taken while an operation is active, so stale BRAM data is dropped.
    assign w_accept     = bus.bram_rvalid &&
                          ((r_state == READER_STATE_ISSUE) || (r_state == READER_STATE_DRAIN));
    assign w_rx_wrap    = (r_received == r_length - 16'd1) && (r_rx_pass != w_rep_m1);

    // Reader FSM, request generator, response counter and registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= READER_STATE_IDLE;
            r_offset     <= '0;
            r_length     <= '0;
            r_issued     <= '0;
            r_received   <= '0;
            r_pass       <= '0;
            r_rx_pass    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bram_re    <= 1'b0;
            r_bram_raddr <= '0;
            r_out_rvalid <= 1'b0;
            r_out_rdata  <= '0;
`ifdef BRAM_READER_REPEAT_EN
            r_rep_m1     <= '0;
`endif
        end else begin
            r_out_rvalid <= w_accept;
            if (w_accept) begin
                r_out_rdata <= bus.bram_rdata;
                if (w_rx_wrap) begin
                    r_received <= '0;
                    r_rx_pass  <= r_rx_pass + 16'd1;
                end else begin
                    r_received <= r_received + 16'd1;
                end
            end else if (r_state == READER_STATE_IDLE) begin
                r_out_rdata <= '0;
            end

            r_done    <= 1'b0;
            r_bram_re <= 1'b0;

            case (r_state)
                READER_STATE_IDLE: begin
                    if (bus.start) begin
                        r_offset   <= bus.access.offset;
                        r_length   <= bus.access.length;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_pass     <= '0;
                        r_rx_pass  <= '0;
                        r_busy     <= 1'b1;
`ifdef BRAM_READER_REPEAT_EN
                        r_rep_m1   <= (bus.repeat_cnt == 16'd0) ? 16'd0 : bus.repeat_cnt - 16'd1;
`endif
                        if (bus.access.length == 16'd0) begin
                            r_state <= READER_STATE_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= READER_STATE_ISSUE;
                        end
                    end
                end
                READER_STATE_ISSUE: begin
                    if (w_can_issue) begin
                        r_bram_re    <= 1'b1;
                        r_bram_raddr <= w_addr_sum[LOG2_DEPTH-1:0];
                        if (w_issue_wrap) begin
                            r_issued <= '0;
                            r_pass   <= r_pass + 16'd1;
                        end else begin
                            r_issued <= r_issued + 16'd1;
                        end
                        if (w_last_issue) begin
                            r_state <= READER_STATE_DRAIN;
                        end
                    end
                end
                READER_STATE_DRAIN: begin
                    // received only reaches length in the final pass, when its last line is on out_rdata.
                    if (r_received == r_length) begin
                        r_state <= READER_STATE_DONE;
                        r_done  <= 1'b1;
                    end
                end
                READER_STATE_DONE: begin
                    r_state <= READER_STATE_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= READER_STATE_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.bram_re    = r_bram_re;
    assign bus.bram_raddr = r_bram_raddr;
    assign bus.out_rvalid = r_out_rvalid;
    assign bus.out_rdata  = r_out_rdata;

endmodule

// File: tb/tb_bram_region_reader.sv
// tb/tb_bram_region_reader.sv - self-checking bench for bram_region_reader (BRAM_READER_REPEAT_EN adds the replay scenario)
module tb_bram_region_reader;

    localparam int WIDTH        = 512;
    localparam int LOG2_DEPTH   = 12;
    localparam int DEPTH        = 1 << LOG2_DEPTH;
    localparam int READ_LATENCY = 2;
    localparam int NO_AF_LO     = 100000;
    localparam int NO_AF_HI     = -1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_region_reader_if #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) bus ();

    bram_region_reader #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [WIDTH-1:0] mem_line(input logic [LOG2_DEPTH-1:0] a);
        logic [31:0] w;
        w = 32'h5A00_0000 ^ {20'd0, a} ^ ({20'd0, a} << 16);
        return {16{w}};
    endfunction

    function automatic logic [LOG2_DEPTH-1:0] exp_addr(input int off, input int len, input int k);
        return LOG2_DEPTH'((off + (k % len)) % DEPTH);
    endfunction

    // Two-stage BRAM model; it is not reset so in-flight reads outlive a DUT reset.
    logic                  p1_v = 1'b0;
    logic                  p2_v = 1'b0;
    logic [LOG2_DEPTH-1:0] p1_a = '0;
    logic [LOG2_DEPTH-1:0] p2_a = '0;
    always @(posedge clk) begin
        p1_v <= bus.bram_re;
        p1_a <= bus.bram_raddr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign bus.bram_rvalid = p2_v;
    assign bus.bram_rdata  = mem_line(p2_a);

    logic [WIDTH-1:0]      exp_q[$];
    logic [WIDTH-1:0]      obs_data[$];
    logic [LOG2_DEPTH-1:0] obs_addr[$];
    int                    obs_re_cyc[$];
    int first_re, done_cyc, done_cnt, start_cyc, stall_re, stall_out, busy_bad;
    logic [WIDTH-1:0] exp_line;

    task automatic push_exp(input int off, input int len, input int rep);
        int eff_rep;
        eff_rep = (rep == 0) ? 1 : rep;
        for (int p = 0; p < eff_rep; p++)
            for (int k = 0; k < len; k++)
                exp_q.push_back(mem_line(exp_addr(off, len, k)));
    endtask

    // Drives one start and records what the DUT does until a few cycles after done.
    task automatic run_op(input int off, input int len, input int rep,
                          input int af_lo, input int af_hi, input bit poke);
        int rel, done_rel, max_cyc, eff_rep, post;
        logic af_prev;
        eff_rep = (rep == 0) ? 1 : rep;
        max_cyc = len * eff_rep + ((af_hi >= af_lo) ? (af_hi - af_lo + 1) : 0) + 40;
        obs_data.delete(); obs_addr.delete(); obs_re_cyc.delete();
        first_re = -1; done_cyc = -1; done_cnt = 0; stall_re = 0; stall_out = 0;
        busy_bad = 0; done_rel = -1; post = 0; af_prev = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.access = {16'(off), 16'(len)};
`ifdef BRAM_READER_REPEAT_EN
        bus.repeat_cnt = 16'(rep);
`endif
        start_cyc = cyc;
        for (int i = 0; i < max_cyc && post < 3; i++) begin
            @(negedge clk);
            rel = cyc - start_cyc;
            if (bus.bram_re) begin
                obs_addr.push_back(bus.bram_raddr);
                obs_re_cyc.push_back(cyc);
                if (first_re < 0) first_re = cyc;
                if (af_prev) stall_re++;
            end
            if (bus.out_rvalid) begin
                obs_data.push_back(bus.out_rdata);
                if (rel >= af_lo + 2 && rel <= af_hi + 1) stall_out++;
            end
            if (done_rel < 0 && !bus.busy) busy_bad++;
            if (done_rel >= 0) begin
                if (post == 0 && bus.busy) busy_bad++;
                post++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_rel < 0) begin
                    done_rel = rel;
                    done_cyc = cyc;
                end
            end
            bus.start  = poke && (rel == 4);
            bus.access = bus.start ? {16'd0, 16'd5} : 32'hFFFF_FFFF;
            bus.out_almostfull = (rel >= af_lo) && (rel <= af_hi);
            af_prev = bus.out_almostfull;
        end
        bus.start = 1'b0;
        bus.out_almostfull = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.bram_re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b want 0", bus.bram_re); end
        checks++; if (bus.bram_raddr !== '0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", bus.bram_raddr); end
        checks++; if (bus.out_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", bus.out_rvalid); end
        checks++; if (bus.out_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.out_rdata[63:0]); end
    endtask

    task automatic test_basic();
        int bad;
        push_exp(0, 8, 1);
        run_op(0, 8, 1, NO_AF_LO, NO_AF_HI, 1'b0);
        bad = 0;
        foreach (obs_addr[k]) if (obs_addr[k] !== exp_addr(0, 8, k)) bad++;
        checks++; if (bad != 0 || obs_addr.size() != 8) begin errors++; $display("FAIL basic_raddr: %0d wrong of %0d issued, want 0 wrong of 8", bad, obs_addr.size()); end
        checks++; if (obs_re_cyc.size() != 8 || obs_re_cyc[$] - obs_re_cyc[0] != 7) begin errors++; $display("FAIL basic_consecutive: re span not 8 back-to-back cycles (%0d reqs)", obs_re_cyc.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_cyc - first_re != 8 + READ_LATENCY + 1) begin errors++; $display("FAIL basic_done_latency: got %0d want %0d", done_cyc - first_re, 8 + READ_LATENCY + 1); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy: got %0d bad cycles want 0", busy_bad); end
        foreach (obs_data[k]) begin
            exp_line = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++; if (obs_data[k] !== exp_line) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", k, obs_data[k][63:0], exp_line[63:0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_lines: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_wrap();
        int bad;
        push_exp(4094, 4, 1);
        run_op(4094, 4, 1, NO_AF_LO, NO_AF_HI, 1'b0);
        bad = 0;
        foreach (obs_addr[k]) if (obs_addr[k] !== exp_addr(4094, 4, k)) bad++;
        checks++; if (bad != 0 || obs_addr.size() != 4) begin errors++; $display("FAIL wrap_raddr: %0d wrong of %0d issued, want 0 wrong of 4", bad, obs_addr.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
        foreach (obs_data[k]) begin
            exp_line = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++; if (obs_data[k] !== exp_line) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", k, obs_data[k][63:0], exp_line[63:0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_lines: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_zero_length();
        run_op(77, 0, 1, NO_AF_LO, NO_AF_HI, 1'b0);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_cyc - start_cyc != 1) begin errors++; $display("FAIL zero_done_latency: got %0d want 1", done_cyc - start_cyc); end
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL zero_re: got %0d requests want 0", obs_addr.size()); end
        checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL zero_rvalid: got %0d lines want 0", obs_data.size()); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL zero_busy: got %0d bad cycles want 0", busy_bad); end
    endtask

    task automatic test_backpressure();
        int bad;
        push_exp(200, 16, 1);
        run_op(200, 16, 1, 3, 9, 1'b0);
        checks++; if (stall_re != 0) begin errors++; $display("FAIL bp_re_during_stall: got %0d want 0", stall_re); end
        checks++; if (stall_out > READ_LATENCY) begin errors++; $display("FAIL bp_lines_during_stall: got %0d want <= %0d", stall_out, READ_LATENCY); end
        bad = 0;
        foreach (obs_addr[k]) if (obs_addr[k] !== exp_addr(200, 16, k)) bad++;
        checks++; if (bad != 0 || obs_addr.size() != 16) begin errors++; $display("FAIL bp_raddr: %0d wrong of %0d issued, want 0 wrong of 16", bad, obs_addr.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
        foreach (obs_data[k]) begin
            exp_line = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++; if (obs_data[k] !== exp_line) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", k, obs_data[k][63:0], exp_line[63:0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lines: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_ignore_start();
        push_exp(300, 6, 1);
        run_op(300, 6, 1, NO_AF_LO, NO_AF_HI, 1'b1);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
        checks++; if (obs_addr.size() != 6) begin errors++; $display("FAIL busy_start_requests: got %0d want 6", obs_addr.size()); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle_after: got %b want 0", bus.busy); end
        foreach (obs_data[k]) begin
            exp_line = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++; if (obs_data[k] !== exp_line) begin errors++; $display("FAIL busy_start_data[%0d]: got %h want %h", k, obs_data[k][63:0], exp_line[63:0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL busy_start_lines: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid();
        int n, late, leaked;
        n = 0; late = 0; leaked = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.access = {16'd100, 16'd10};
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.bram_re) n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rst_reach_line5: got %0d requests want 5", n); end
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done, bus.bram_re, bus.out_rvalid} !== 4'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 0000", {bus.busy, bus.done, bus.bram_re, bus.out_rvalid}); end
        checks++; if (bus.bram_raddr !== '0) begin errors++; $display("FAIL rst_raddr: got %0d want 0", bus.bram_raddr); end
        checks++; if (bus.out_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.out_rdata[63:0]); end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.bram_rvalid) late++;
            if (bus.out_rvalid || bus.done || bus.bram_re || bus.busy) leaked++;
        end
        checks++; if (leaked != 0) begin errors++; $display("FAIL rst_leak: got %0d active cycles want 0", leaked); end
        checks++; if (late == 0) begin errors++; $display("FAIL rst_inflight: got %0d late responses want > 0", late); end
        push_exp(20, 4, 1);
        run_op(20, 4, 1, NO_AF_LO, NO_AF_HI, 1'b0);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_restart_done: got %0d want 1", done_cnt); end
        foreach (obs_data[k]) begin
            exp_line = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++; if (obs_data[k] !== exp_line) begin errors++; $display("FAIL rst_restart_data[%0d]: got %h want %h", k, obs_data[k][63:0], exp_line[63:0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_restart_lines: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
    endtask

`ifdef BRAM_READER_REPEAT_EN
    task automatic test_repeat();
        int bad;
        push_exp(10, 3, 2);
        run_op(10, 3, 2, NO_AF_LO, NO_AF_HI, 1'b0);
        bad = 0;
        foreach (obs_addr[k]) if (obs_addr[k] !== exp_addr(10, 3, k)) bad++;
        checks++; if (bad != 0 || obs_addr.size() != 6) begin errors++; $display("FAIL rep_raddr: %0d wrong of %0d issued, want 0 wrong of 6", bad, obs_addr.size()); end
        checks++; if (obs_re_cyc.size() != 6 || obs_re_cyc[$] - obs_re_cyc[0] != 5) begin errors++; $display("FAIL rep_consecutive: passes not back to back (%0d reqs)", obs_re_cyc.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rep_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_cyc - first_re != 6 + READ_LATENCY + 1) begin errors++; $display("FAIL rep_done_latency: got %0d want %0d", done_cyc - first_re, 6 + READ_LATENCY + 1); end
        foreach (obs_data[k]) begin
            exp_line = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++; if (obs_data[k] !== exp_line) begin errors++; $display("FAIL rep_data[%0d]: got %h want %h", k, obs_data[k][63:0], exp_line[63:0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rep_lines: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
        push_exp(50, 2, 0);
        run_op(50, 2, 0, NO_AF_LO, NO_AF_HI, 1'b0);
        checks++; if (obs_addr.size() != 2) begin errors++; $display("FAIL rep_zero_requests: got %0d want 2", obs_addr.size()); end
        foreach (obs_data[k]) begin
            exp_line = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++; if (obs_data[k] !== exp_line) begin errors++; $display("FAIL rep_zero_data[%0d]: got %h want %h", k, obs_data[k][63:0], exp_line[63:0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rep_zero_lines: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
    endtask
`endif

    initial begin
        bus.start          = 1'b0;
        bus.access         = '0;
        bus.out_almostfull = 1'b0;
`ifdef BRAM_READER_REPEAT_EN
        bus.repeat_cnt     = 16'd1;
`endif
        test_reset();
        test_basic();
        test_wrap();
        test_zero_length();
        test_backpressure();
        test_ignore_start();
        test_reset_mid();
`ifdef BRAM_READER_REPEAT_EN
        test_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
